spi_reg_bank_ctrl: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 20 ++
 rtl/spi_ctrl_sync.sv | 28 ++
 rtl/spi_reg_bank_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_reg_bank_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and defaults for the SPI register-bank controller.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StCommit,
    StClear
  } spi_ctrl_state_t;

  localparam int unsigned DefDataWidth  = 16;
  localparam int unsigned DefNumRegs    = 16;
  localparam int unsigned DefClrTimeout = 64;

  // Register map shared with the motor control core
  localparam int unsigned RegVelSetpoint = 0;
  localparam int unsigned RegVelMeasured = 1;
  localparam int unsigned RegStatus      = 2;

endpackage

// File: rtl/spi_ctrl_sync.sv
// Two-flop synchronizer for a slow-changing bus crossing from the SPI domain.
module spi_ctrl_sync
  import spi_reg_pkg::*;
#(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bank_ctrl.sv
// Register-bank controller: sequences SPI new-data handshakes and arbitrates the bank
// between SPI commits and a local write port.
module spi_reg_bank_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned       DataWidth  = DefDataWidth,
  parameter int unsigned       NumRegs    = DefNumRegs,
  parameter int unsigned       AddrW      = $clog2(NumRegs),
  parameter logic [NumRegs-1:0] RoMask    = '0,
  parameter int unsigned       ClrTimeout = DefClrTimeout
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 spi_new_data_flag_i,
  output logic                 spi_clear_flag_o,
  input  logic [DataWidth-1:0] spi_address_i,
  input  logic                 spi_write_enable_i,
  input  logic [DataWidth-1:0] spi_data_received_i,
  output logic [DataWidth-1:0] spi_data_to_send_o,
  input  logic                 lcl_wr_req_i,
  input  logic [AddrW-1:0]     lcl_wr_addr_i,
  input  logic [DataWidth-1:0] lcl_wr_data_i,
  output logic                 lcl_wr_ack_o,
  input  logic [AddrW-1:0]     lcl_rd_addr_i,
  output logic [DataWidth-1:0] lcl_rd_data_o,
  output logic                 spi_wr_strobe_o,
  output logic [AddrW-1:0]     spi_wr_addr_o,
  output logic                 clr_timeout_err_o,
  input  logic                 err_clear_i
);

  localparam int unsigned CntW   = $clog2(ClrTimeout + 1);
  localparam int unsigned RangeW = DataWidth - 1;

  spi_ctrl_state_t      state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [DataWidth-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] dts_q, dts_d;
  logic [AddrW-1:0]     wr_addr_q, wr_addr_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [DataWidth-1:0] regs_d [NumRegs];

  logic [DataWidth:0]   sync_out;
  logic [AddrW-1:0]     idx;
  logic                 in_range, ro_hit, spi_wr_ok, lcl_ok;
  logic [DataWidth-1:0] bypass_word, lcl_rd_word;

  spi_ctrl_sync #(
    .Width(DataWidth + 1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   ({spi_write_enable_i, spi_address_i}),
    .q_o   (sync_out)
  );

  // MSB of the SPI address word is the slave's R/W command bit, not part of the index
  assign idx      = addr_q[AddrW-1:0];
  assign in_range = addr_q[RangeW-1:0] < RangeW'(NumRegs);

  always_comb begin
    ro_hit = 1'b0;
    for (int i = 0; i < NumRegs; i++) begin
      if (idx == AddrW'(i)) ro_hit = RoMask[i];
    end
  end

  assign spi_wr_ok = (state_q == StCommit) && we_q && in_range && !ro_hit;
  assign lcl_ok    = lcl_wr_req_i && !(spi_wr_ok && (lcl_wr_addr_i == idx));

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      regs_d[i] = regs_q[i];
      if (spi_wr_ok && idx == AddrW'(i)) begin
        regs_d[i] = data_q;
      end else if (lcl_ok && lcl_wr_addr_i == AddrW'(i)) begin
        regs_d[i] = lcl_wr_data_i;
      end
    end
  end

  // Preload reads the post-write bank so same-cycle commits are visible to the master
  always_comb begin
    bypass_word = '0;
    lcl_rd_word = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (idx == AddrW'(i))           bypass_word = regs_d[i];
      if (lcl_rd_addr_i == AddrW'(i)) lcl_rd_word = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    addr_d    = addr_q;
    we_d      = we_q;
    dts_d     = dts_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_clear_i ? 1'b0 : err_q;
    unique case (state_q)
      StIdle: begin
        if (spi_new_data_flag_i) state_d = StCapture;
      end
      StCapture: begin
        data_d  = spi_data_received_i;
        addr_d  = sync_out[DataWidth-1:0];
        we_d    = sync_out[DataWidth];
        state_d = StCommit;
      end
      StCommit: begin
        dts_d = in_range ? bypass_word : '0;
        if (spi_wr_ok) wr_addr_d = idx;
        cnt_d   = '0;
        state_d = StClear;
      end
      StClear: begin
        if (!spi_new_data_flag_i) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == CntW'(ClrTimeout - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      dts_q     <= '0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      dts_q     <= dts_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign spi_clear_flag_o   = (state_q == StClear) && spi_new_data_flag_i;
  assign spi_data_to_send_o = dts_q;
  assign lcl_wr_ack_o       = lcl_ok;
  assign lcl_rd_data_o      = lcl_rd_word;
  assign spi_wr_strobe_o    = spi_wr_ok;
  assign spi_wr_addr_o      = wr_addr_q;
  assign clr_timeout_err_o  = err_q;

endmodule

// File: tb/tb_spi_reg_bank_ctrl.sv
// Scoreboard bench: each SPI transfer pushes its expected preload/strobe outcome; a monitor
// checks it when the DUT raises the clear handshake.
module tb_spi_reg_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag = 1'b0;
  logic        clear_flag;
  logic [15:0] spi_addr = '0;
  logic        spi_we = 1'b0;
  logic [15:0] spi_data = '0;
  logic [15:0] dts;
  logic        lcl_req = 1'b0;
  logic [3:0]  lcl_waddr = '0;
  logic [15:0] lcl_wdata = '0;
  logic        lcl_ack;
  logic [3:0]  lcl_raddr = '0;
  logic [15:0] lcl_rdata;
  logic        strobe;
  logic [3:0]  wr_addr;
  logic        err;
  logic        err_clear = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] dts;
    logic [3:0]  wra;
    int          strobes;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   strobe_seen = 0;
  logic clr_prev = 1'b0;

  always #5 clk = ~clk;

  spi_reg_bank_ctrl #(
    .RoMask(16'h0020)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .spi_new_data_flag_i(flag),
    .spi_clear_flag_o   (clear_flag),
    .spi_address_i      (spi_addr),
    .spi_write_enable_i (spi_we),
    .spi_data_received_i(spi_data),
    .spi_data_to_send_o (dts),
    .lcl_wr_req_i       (lcl_req),
    .lcl_wr_addr_i      (lcl_waddr),
    .lcl_wr_data_i      (lcl_wdata),
    .lcl_wr_ack_o       (lcl_ack),
    .lcl_rd_addr_i      (lcl_raddr),
    .lcl_rd_data_o      (lcl_rdata),
    .spi_wr_strobe_o    (strobe),
    .spi_wr_addr_o      (wr_addr),
    .clr_timeout_err_o  (err),
    .err_clear_i        (err_clear)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per rising edge of the clear handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_seen = 0;
      clr_prev    = 1'b0;
    end else begin
      if (strobe) strobe_seen++;
      if (clear_flag && !clr_prev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_clear: got clear with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data_to_send", {16'h0, dts}, {16'h0, e.dts});
          chk("sb_spi_wr_addr", {28'h0, wr_addr}, {28'h0, e.wra});
          chk("sb_strobe_count", strobe_seen, e.strobes);
        end
        strobe_seen = 0;
      end
      clr_prev = clear_flag;
    end
  end

  // Present SPI-domain inputs long enough to pass the synchronizer
  task automatic setup_spi(input logic [15:0] a, input logic w, input logic [15:0] d);
    spi_addr = a;
    spi_we   = w;
    spi_data = d;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input logic lvl, input string nm);
    int k = 0;
    @(negedge clk);
    while (clear_flag !== lvl && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'h0, clear_flag}, {31'h0, lvl});
  endtask

  // Full handshake; entered and left at posedge+1
  task automatic run_flag(input string nm);
    flag = 1'b1;
    wait_clear(1'b1, {nm, "_clear_rise"});
    repeat (2) @(negedge clk);
    chk({nm, "_clear_held"}, {31'h0, clear_flag}, 32'h1);
    @(posedge clk);
    #1 flag = 1'b0;
    @(negedge clk);
    chk({nm, "_clear_drop"}, {31'h0, clear_flag}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic lcl_write(input logic [3:0] a, input logic [15:0] d, input string nm);
    int k = 0;
    lcl_req   = 1'b1;
    lcl_waddr = a;
    lcl_wdata = d;
    @(negedge clk);
    while (!lcl_ack && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'h0, lcl_ack}, 32'h1);
    @(posedge clk);
    #1 lcl_req = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] exp, input string nm);
    lcl_raddr = a;
    #1 chk(nm, {16'h0, lcl_rdata}, {16'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_clear_flag", {31'h0, clear_flag}, 32'h0);
    chk("rst_data_to_send", {16'h0, dts}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_wr_addr", {28'h0, wr_addr}, 32'h0);
    chk("rst_strobe_ack", {30'h0, strobe, lcl_ack}, 32'h0);
    @(posedge clk);
    #1;

    // 1: write 0x1234 to reg 3 (address MSB is the R/W bit)
    setup_spi(16'h8003, 1'b1, 16'h1234);
    exp_q.push_back('{16'h1234, 4'd3, 1});
    run_flag("t1");
    rd(4'd3, 16'h1234, "t1_reg3");

    // SPI read of reg 3
    setup_spi(16'h0003, 1'b0, 16'h0000);
    exp_q.push_back('{16'h1234, 4'd3, 0});
    run_flag("t1r");

    // 2: reg 5 is read-only to SPI; local port may still write it
    lcl_write(4'd5, 16'h1111, "t2_lcl_ack");
    setup_spi(16'h0005, 1'b1, 16'hBEEF);
    exp_q.push_back('{16'h1111, 4'd3, 0});
    run_flag("t2");
    rd(4'd5, 16'h1111, "t2_reg5");

    // 3: SPI and local collide on reg 2; SPI first, local acked the next cycle
    setup_spi(16'h0002, 1'b1, 16'hA5A5);
    exp_q.push_back('{16'hA5A5, 4'd2, 1});
    fork
      run_flag("t3");
      begin
        repeat (2) @(posedge clk);
        #1;
        lcl_req   = 1'b1;
        lcl_waddr = 4'd2;
        lcl_wdata = 16'h0055;
        @(negedge clk);
        chk("t3_ack_stalled", {31'h0, lcl_ack}, 32'h0);
        @(negedge clk);
        chk("t3_ack_retry", {31'h0, lcl_ack}, 32'h1);
        @(posedge clk);
        #1 lcl_req = 1'b0;
      end
    join
    rd(4'd2, 16'h0055, "t3_reg2");

    // 4: different indices commit together
    setup_spi(16'h0001, 1'b1, 16'h0F0F);
    exp_q.push_back('{16'h0F0F, 4'd1, 1});
    fork
      run_flag("t4");
      begin
        repeat (2) @(posedge clk);
        #1;
        lcl_req   = 1'b1;
        lcl_waddr = 4'd7;
        lcl_wdata = 16'h7777;
        @(negedge clk);
        chk("t4_ack_same_cycle", {31'h0, lcl_ack}, 32'h1);
        @(posedge clk);
        #1 lcl_req = 1'b0;
      end
    join
    rd(4'd7, 16'h7777, "t4_reg7");
    rd(4'd1, 16'h0F0F, "t4_reg1");

    // Local write to the word being preloaded shows up in data_to_send
    setup_spi(16'h0006, 1'b0, 16'h0000);
    exp_q.push_back('{16'h6666, 4'd1, 0});
    fork
      run_flag("t4b");
      begin
        repeat (2) @(posedge clk);
        #1;
        lcl_req   = 1'b1;
        lcl_waddr = 4'd6;
        lcl_wdata = 16'h6666;
        @(negedge clk);
        chk("t4b_ack", {31'h0, lcl_ack}, 32'h1);
        @(posedge clk);
        #1 lcl_req = 1'b0;
      end
    join

    // Out-of-range address 0x13: write dropped, read returns 0
    setup_spi(16'h0013, 1'b1, 16'hDEAD);
    exp_q.push_back('{16'h0000, 4'd1, 0});
    run_flag("toor");
    rd(4'd3, 16'h1234, "toor_reg3_kept");

    // 5: flag stuck high -> timeout after 64 cycles of clear
    setup_spi(16'h0003, 1'b0, 16'h0000);
    exp_q.push_back('{16'h1234, 4'd1, 0});
    flag = 1'b1;
    wait_clear(1'b1, "t5_clear_rise");
    n = 1;
    @(negedge clk);
    while (clear_flag && n < 200) begin
      n++;
      @(negedge clk);
    end
    flag = 1'b0;
    chk("t5_clear_cycles", n, 64);
    chk("t5_err_set", {31'h0, err}, 32'h1);
    @(posedge clk);
    #1 err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    @(negedge clk);
    chk("t5_err_cleared", {31'h0, err}, 32'h0);
    @(posedge clk);
    #1;

    // 6: reset in the middle of CLEAR
    setup_spi(16'h0002, 1'b0, 16'h0000);
    exp_q.push_back('{16'h0055, 4'd1, 0});
    flag = 1'b1;
    wait_clear(1'b1, "t6_clear_rise");
    #2 rst_n = 1'b0;
    #1 chk("t6_clear_async", {31'h0, clear_flag}, 32'h0);
    chk("t6_dts_reset", {16'h0, dts}, 32'h0);
    rd(4'd2, 16'h0000, "t6_reg2_reset");
    flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    setup_spi(16'h0020, 1'b0, 16'h0000);
    exp_q.push_back('{16'h0000, 4'd0, 0});
    run_flag("t6r");

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
